// File: rtl/ecdsa_req_sched_pkg.sv
// Shared encodings for the ECDSA request scheduler:
// FSM states, response status codes and the real-time width.
package ecdsa_req_sched_pkg;

   localparam int REAL_TIME_NBITS = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } sched_state_t;

   localparam logic [1:0] ECDSA_RSP_PASS    = 2'b01;
   localparam logic [1:0] ECDSA_RSP_FAIL    = 2'b10;
   localparam logic [1:0] ECDSA_RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/ecdsa_rr_arb.sv
// Combinational round-robin picker: first set request at or
// after ptr, scanning upward and wrapping to index 0.
module ecdsa_rr_arb #(
   parameter int NUM_REQ   = 4,
   parameter int IDX_NBITS = 2
) (
   input  logic [NUM_REQ-1:0]   req,
   input  logic [IDX_NBITS-1:0] ptr,
   output logic [IDX_NBITS-1:0] idx,
   output logic                 found
);

   int unsigned pos;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = (int'(ptr) + i) % NUM_REQ;
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IDX_NBITS'(pos);
         end
      end
   end

endmodule

// File: rtl/ecdsa_req_sched.sv
// Round-robin scheduler sharing one ECDSA verify engine among
// NUM_REQ requesters, with a per-job tick timeout.
module ecdsa_req_sched
   import ecdsa_req_sched_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int REQ_IDX_NBITS = 2,
   parameter int TIME_NBITS    = REAL_TIME_NBITS,
   parameter int TO_CNT_NBITS  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clk_div,
   input  logic [TIME_NBITS-1:0]    default_exp_time,
   input  logic [NUM_REQ-1:0]       req,
   output logic                     eng_start,
   output logic [REQ_IDX_NBITS-1:0] eng_sel,
   output logic                     eng_abort,
   input  logic                     eng_done,
   input  logic                     eng_pass,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [1:0]               rsp_status,
   output logic                     busy,
   output logic [TO_CNT_NBITS-1:0]  to_cnt
);

   localparam logic [REQ_IDX_NBITS-1:0] LAST_IDX =
      REQ_IDX_NBITS'(NUM_REQ - 1);

   sched_state_t              state, state_n;
   logic [REQ_IDX_NBITS-1:0]  ptr, ptr_n;
   logic [REQ_IDX_NBITS-1:0]  sel, sel_n;
   logic [REQ_IDX_NBITS-1:0]  pick;
   logic                      found;
   logic [TIME_NBITS-1:0]     timer, timer_n;
   logic                      to_dis, to_dis_n;
   logic [1:0]                status, status_n;
   logic [TO_CNT_NBITS-1:0]   cnt_n;

   ecdsa_rr_arb #(
      .NUM_REQ   (NUM_REQ),
      .IDX_NBITS (REQ_IDX_NBITS)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .idx   (pick),
      .found (found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         ptr    <= '0;
         sel    <= '0;
         timer  <= '0;
         to_dis <= 1'b0;
         status <= '0;
         to_cnt <= '0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         sel    <= sel_n;
         timer  <= timer_n;
         to_dis <= to_dis_n;
         status <= status_n;
         to_cnt <= cnt_n;
      end
   end

   always_comb begin
      state_n   = state;
      ptr_n     = ptr;
      sel_n     = sel;
      timer_n   = timer;
      to_dis_n  = to_dis;
      status_n  = status;
      cnt_n     = to_cnt;
      eng_start = 1'b0;
      eng_abort = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (found) begin
               sel_n   = pick;
               ptr_n   = (pick == LAST_IDX) ? '0 : pick + 1'b1;
               state_n = S_START;
            end
         end
         S_START: begin
            eng_start = 1'b1;
            timer_n   = default_exp_time;
            to_dis_n  = &default_exp_time;
            state_n   = S_WAIT;
         end
         S_WAIT: begin
            // completion beats a coincident expiry tick
            if (eng_done) begin
               status_n = eng_pass ? ECDSA_RSP_PASS : ECDSA_RSP_FAIL;
               state_n  = S_RESP;
            end else if (!to_dis && clk_div) begin
               if (timer == '0) begin
                  eng_abort = 1'b1;
                  status_n  = ECDSA_RSP_TIMEOUT;
                  if (!(&to_cnt)) cnt_n = to_cnt + 1'b1;
                  state_n   = S_RESP;
               end else begin
                  timer_n = timer - 1'b1;
               end
            end
         end
         S_RESP: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      rsp_valid = '0;
      if (state == S_RESP) rsp_valid[sel] = 1'b1;
   end

   assign rsp_status = (state == S_RESP) ? status : 2'b00;
   assign eng_sel    = sel;
   assign busy       = (state != S_IDLE);

endmodule
